// File: rtl/light_pkg.sv
// Shared constants and state type for the light sequencer and the pattern decoder bank.
// Contents: selector width and code count, dwell register width, reset dwell, FSM state enum.
package light_pkg;

  localparam int unsigned LIGHT_SEL_W         = 6;
  localparam int unsigned LIGHT_STEPS         = 60;
  localparam int unsigned LIGHT_DWELL_W       = 16;
  localparam int unsigned LIGHT_DEFAULT_DWELL = 1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } light_state_e;

endpackage

// File: rtl/light_dwell_timer.sv
// Dwell timer: holds the programmable dwell register, the dwell captured for the
// code currently shown, and the per-code cycle counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   dwell_load      pulse, capture dwell_val into the dwell register (0 stored as 1)
//   dwell_val       requested dwell in cycles
//   restart         clear the counter and recapture the active dwell (start/stop/step)
//   count_en        advance the counter this cycle
//   expire_c        combinational: the current code has been shown for the full dwell
module light_dwell_timer
  import light_pkg::*;
#(
  parameter int unsigned DEFAULT_DWELL = LIGHT_DEFAULT_DWELL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dwell_load,
  input  logic [LIGHT_DWELL_W-1:0] dwell_val,
  input  logic                     restart,
  input  logic                     count_en,
  output logic                     expire_c
);

  localparam int unsigned W = LIGHT_DWELL_W;

  logic [W-1:0] dwell_reg;
  logic [W-1:0] active_dwell;
  logic [W-1:0] cnt;

  // active_dwell is never 0, so active_dwell-1 cannot underflow and cnt never overflows
  assign expire_c = count_en && !restart && (cnt == (active_dwell - W'(1)));

  // Register and counter; a newly loaded dwell only takes effect at the next boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg    <= W'(DEFAULT_DWELL);
      active_dwell <= W'(DEFAULT_DWELL);
      cnt          <= '0;
    end else begin
      if (dwell_load) begin
        dwell_reg <= (dwell_val == '0) ? W'(1) : dwell_val;
      end
      if (restart || expire_c) begin
        cnt          <= '0;
        active_dwell <= dwell_reg;
      end else if (count_en) begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Light sequencer: steps the shared 6-bit pattern selector through codes 0..STEPS-1
// at a programmable dwell, with start/stop, pause + single-step and one-shot/loop runs.
// Optional feature: define LIGHT_SEQ_REVERSE_EN to add the dir input (1 = count down).
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, stop          pulses; begin a run from the first code / abort to IDLE
//   pause, step_req      freeze while high / advance one code while frozen
//   one_shot             sampled at start; 1 = end after the last code, 0 = loop
//   dwell_load/dwell_val load a new dwell (cycles per code, 0 treated as 1)
//   dir                  (LIGHT_SEQ_REVERSE_EN only) direction, sampled at start and boundaries
//   sel, sel_valid       selector and its qualifier
//   busy                 high in RUN or PAUSE
//   wrap, done           one-cycle pulses: loop wrap-around / one-shot completion
module light_sequencer
  import light_pkg::*;
#(
  parameter int unsigned DEFAULT_DWELL = LIGHT_DEFAULT_DWELL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     pause,
  input  logic                     step_req,
  input  logic                     one_shot,
  input  logic                     dwell_load,
  input  logic [LIGHT_DWELL_W-1:0] dwell_val,
`ifdef LIGHT_SEQ_REVERSE_EN
  input  logic                     dir,
`endif
  output logic [LIGHT_SEL_W-1:0]   sel,
  output logic                     sel_valid,
  output logic                     busy,
  output logic                     wrap,
  output logic                     done
);

  localparam int unsigned SEL_W = LIGHT_SEL_W;
  localparam int unsigned STEPS = LIGHT_STEPS;

  light_state_e     state;
  logic             one_shot_q;
  logic             dir_c;
  logic             running_c;
  logic             step_c;
  logic             count_en_c;
  logic             restart_c;
  logic             expire_c;
  logic             boundary_c;
  logic [SEL_W-1:0] first_c;
  logic [SEL_W-1:0] last_c;
  logic [SEL_W-1:0] next_sel_c;

`ifdef LIGHT_SEQ_REVERSE_EN
  assign dir_c = dir;
`else
  assign dir_c = 1'b0;
`endif

  // Priority decode: stop > start > pause > step_req > dwell expiry
  assign running_c  = (state != ST_IDLE);
  assign step_c     = (state == ST_PAUSE) && pause && step_req && !stop && !start;
  assign count_en_c = running_c && !pause && !stop && !start;
  assign restart_c  = stop || start || step_c;
  assign boundary_c = step_c || expire_c;

  // First/last code for the direction in force; compared explicitly, never via 2^SEL_W wrap
  assign first_c    = dir_c ? SEL_W'(STEPS - 1) : '0;
  assign last_c     = dir_c ? '0 : SEL_W'(STEPS - 1);
  assign next_sel_c = dir_c ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));

  light_dwell_timer #(
    .DEFAULT_DWELL (DEFAULT_DWELL)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .dwell_load (dwell_load),
    .dwell_val  (dwell_val),
    .restart    (restart_c),
    .count_en   (count_en_c),
    .expire_c   (expire_c)
  );

  // Sequencer FSM with registered selector and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      sel_valid  <= 1'b0;
      busy       <= 1'b0;
      wrap       <= 1'b0;
      done       <= 1'b0;
      one_shot_q <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state     <= ST_IDLE;
        sel       <= '0;
        sel_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (start) begin
        state      <= ST_RUN;
        sel        <= first_c;
        sel_valid  <= 1'b1;
        busy       <= 1'b1;
        one_shot_q <= one_shot;
      end else if (running_c) begin
        state <= pause ? ST_PAUSE : ST_RUN;
        if (boundary_c) begin
          if (sel == last_c) begin
            if (one_shot_q) begin
              // One-shot end: the last code stays on sel for the decoders' benefit
              state     <= ST_IDLE;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              sel  <= first_c;
              wrap <= 1'b1;
            end
          end else begin
            sel <= next_sel_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer: expected outputs are queued per cycle and
// compared against the DUT one time unit after each rising edge.
module tb_light_sequencer;
  import light_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, pause, step_req, one_shot, dwell_load;
  logic [15:0] dwell_val;
  logic        dir;
  logic [5:0]  sel;
  logic        sel_valid, busy, wrap, done;

  typedef struct packed {
    logic [5:0] sel;
    logic       v;
    logic       b;
    logic       w;
    logic       d;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  light_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .step_req   (step_req),
    .one_shot   (one_shot),
    .dwell_load (dwell_load),
    .dwell_val  (dwell_val),
`ifdef LIGHT_SEQ_REVERSE_EN
    .dir        (dir),
`endif
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done)
  );

  task automatic expect_out(input string tag, input int s, input logic v, input logic b,
                            input logic w, input logic d);
    obs_t e;
    e.sel = 6'(s);
    e.v   = v;
    e.b   = b;
    e.w   = w;
    e.d   = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_now();
    obs_t  e;
    obs_t  o;
    string t;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {sel, sel_valid, busy, wrap, done};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed sel=%0d valid=%b busy=%b wrap=%b done=%b, expected sel=%0d valid=%b busy=%b wrap=%b done=%b",
             t, o.sel, o.v, o.b, o.w, o.d, e.sel, e.v, e.b, e.w, e.d);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  // Load a dwell from IDLE; cur_sel is the selector value IDLE is holding
  task automatic load_dwell(input int d, input int cur_sel);
    dwell_load = 1'b1;
    dwell_val  = 16'(d);
    expect_out("load_idle", cur_sel, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    dwell_load = 1'b0;
  endtask

  task automatic do_start(input logic os, input int first);
    start    = 1'b1;
    one_shot = os;
    expect_out("start", first, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    expect_out("stop", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    stop = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    pause      = 1'b0;
    step_req   = 1'b0;
    one_shot   = 1'b0;
    dwell_load = 1'b0;
    dwell_val  = '0;
    dir        = 1'b0;

    // Reset state
    #2;
    expect_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_now();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_out("idle_after_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Looping run, D=3: 180 cycles returns to code 0 with one wrap pulse
    load_dwell(3, 0);
    do_start(1'b0, 0);
    for (int t = 1; t <= 180; t++) begin
      expect_out("loop_d3", (t / 3) % 60, 1'b1, 1'b1, t == 180, 1'b0);
      tick();
    end
    expect_out("loop_d3_after_wrap", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // stop and start together: stop wins
    start = 1'b1;
    stop  = 1'b1;
    expect_out("stop_start_same", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    stop  = 1'b0;
    expect_out("idle_after_stop", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // One-shot with dwell_val=0 (treated as 1): 0..59, then done, hold 59
    load_dwell(0, 0);
    do_start(1'b1, 0);
    for (int t = 1; t <= 59; t++) begin
      expect_out("oneshot_d1", t, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    expect_out("oneshot_done", 59, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_out("oneshot_hold", 59, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Pause at count 2 with D=4, three single steps, then resume
    load_dwell(4, 59);
    do_start(1'b0, 0);
    expect_out("pause_pre", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("pause_pre", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_out("paused_frozen", 0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      expect_out("paused_step", i, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step_req = 1'b0;
    pause    = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      expect_out("resume", (i == 4) ? 4 : 3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    step_req = 1'b1;
    expect_out("step_ignored_run", 4, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    step_req = 1'b0;
    do_stop();

    // Dwell reload mid-code: current code keeps D=5, next lasts 10, then 0 -> 1-cycle codes
    load_dwell(5, 0);
    do_start(1'b0, 0);
    expect_out("dwell5", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out("dwell5", 0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    dwell_load = 1'b1;
    dwell_val  = 16'd10;
    for (int t = 3; t <= 15; t++) begin
      expect_out("dwell_reload10", (t < 5) ? 0 : ((t < 15) ? 1 : 2), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      dwell_load = 1'b0;
    end
    dwell_load = 1'b1;
    dwell_val  = 16'd0;
    for (int t = 16; t <= 27; t++) begin
      expect_out("dwell_reload0", (t < 25) ? 2 : (t - 22), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      dwell_load = 1'b0;
    end
    do_stop();

    // Asynchronous reset mid-run at sel=37; dwell returns to the 1000-cycle default
    do_start(1'b0, 0);
    for (int t = 1; t <= 37; t++) begin
      expect_out("run_to_37", t, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_now();
    @(posedge clk);
    #1;
    expect_out("reset_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_now();
    rst_n = 1'b1;
    do_start(1'b0, 0);
    for (int t = 1; t <= 5; t++) begin
      expect_out("default_dwell", 0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    do_stop();

`ifdef LIGHT_SEQ_REVERSE_EN
    // Down-counting loop: 59..0, then wrap to 59
    load_dwell(1, 0);
    dir = 1'b1;
    do_start(1'b0, 59);
    for (int t = 1; t <= 60; t++) begin
      expect_out("reverse_loop", (t == 60) ? 59 : (59 - t), 1'b1, 1'b1, t == 60, 1'b0);
      tick();
    end
    dir = 1'b0;
    do_stop();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Time-base controller for the light-pattern decoders: generates the 6-bit selector shared by every pattern decoder and steps it through the pattern table at a programmable dwell rate. Supports start/stop, pause with single-step, and one-shot or looping runs. Sits between the front-panel control logic and the decoder bank; its `sel` output fans out unregistered to all decoders.

## Interface
- `STEPS`, 60: number of valid selector codes, 0..STEPS-1; codes ≥ STEPS are never driven.
- `SEL_W`, 6: selector width.
- `DWELL_W`, 16: dwell register width.
- `DEFAULT_DWELL`, 1000: dwell value at reset, in clock cycles.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: pulse; begin a run from code 0.
- `stop`, in, 1: pulse; abort the run and return to IDLE.
- `pause`, in, 1: level; freeze while high.
- `step_req`, in, 1: pulse; advance one code while paused.
- `one_shot`, in, 1: sampled at start; 1 = stop after the last code, 0 = loop.
- `dwell_load`, in, 1: pulse; capture `dwell_val`.
- `dwell_val`, in, DWELL_W: new dwell in cycles; 0 is treated as 1.
- `dir`, in, 1: present only with LIGHT_SEQ_REVERSE_EN; 1 = count down.
- `sel`, out, SEL_W: current selector.
- `sel_valid`, out, 1: decoders should drive lights.
- `busy`, out, 1: high in RUN or PAUSE.
- `wrap`, out, 1: one-cycle pulse on wrap-around.
- `done`, out, 1: one-cycle pulse when a one-shot run ends.

## Operation
- States: IDLE, RUN, PAUSE.
- Reset values: state IDLE, `sel`=0, `sel_valid`=0, `busy`=0, `wrap`=0, `done`=0, dwell register = DEFAULT_DWELL, dwell counter = 0.
- IDLE → RUN on `start`:
  - `sel` is set to 0 (STEPS-1 when counting down).
  - Dwell counter cleared; `one_shot` latched.
- RUN holds each code for exactly D cycles, where D is the active dwell.
  - At a step boundary, `sel` advances by ±1 and the counter clears.
- Active dwell is copied from the dwell register at every step boundary and at start.
  - `dwell_load` writes the register at any time, in any state.
  - A new value never shortens or stretches the code currently being shown.
- Boundary step from the last code (STEPS-1 up, 0 down):
  - Looping: `sel` wraps to the first code and `wrap` pulses in the same cycle as the new `sel`.
  - One-shot: go to IDLE, pulse `done`, `sel` holds the last code, `sel_valid`/`busy` drop. No `wrap` pulse.
- RUN → PAUSE while `pause`=1; the counter is frozen. PAUSE → RUN when `pause`=0; counting resumes from the frozen value.
- `step_req` in PAUSE:
  - Performs one step boundary on the next edge (including wrap/done handling) and clears the counter.
  - Ignored in RUN and IDLE.
- Priority in one cycle: `stop` > `start` > `pause` > `step_req` > dwell expiry.
  - `stop` from any state: IDLE next edge, `sel`=0, no wrap/done.
  - `start` while busy restarts from the first code.
  - `start` and `stop` together: stop wins.
- Arithmetic:
  - Dwell counter is DWELL_W bits and compares against active dwell − 1; no overflow is possible.
  - `sel` arithmetic compares explicitly against STEPS-1; it never relies on natural 2^SEL_W wrap.
- Reset asserted mid-run returns all outputs to reset values immediately. The dwell register returns to DEFAULT_DWELL.

## Timing
- All outputs are registered. `start` at edge N gives `busy`=`sel_valid`=1 and `sel`=0 after edge N.
- With active dwell D, `sel` changes every D cycles; D=1 changes `sel` every cycle.
- `step_req` latency is one cycle.
- `wrap` and `done` are exactly one cycle wide.
- A full looping cycle is STEPS×D cycles.

## Configuration
- `LIGHT_SEQ_REVERSE_EN` defined:
  - Adds the `dir` port.
  - `dir` is sampled only at step boundaries and at start.
  - Down-counting runs STEPS-1 → 0, then wraps to STEPS-1 (looping) or ends at 0 (one-shot).
  - A direction change mid-run continues from the current code.
- Undefined: no `dir` port; the sequencer always counts up.

## Structure
- Shared package `light_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE);
  - `LIGHT_SEL_W`=6 and `LIGHT_STEPS`=60;
  - the dwell-width constant.
  
  The decoder bank uses the same constants.
- One sub-module, `light_dwell_timer`: dwell register, active-dwell capture, counter and expiry pulse. The FSM and selector stay in the top.

## Test plan
- Reset, then `start` with D=3, `one_shot`=0 → `sel` steps 0,1,2 every 3 cycles; after 180 cycles `sel` is back to 0 with a single `wrap` pulse.
- `one_shot`=1, D=1 → `sel` runs 0..59 over 60 cycles, then `done` pulses once, `busy`=0, `sel` holds 59.
- In RUN with D=4, pull `pause` high at count 2 → `sel` frozen; 3× `step_req` → `sel` +3, one per cycle; release `pause` → next code after 4 cycles.
- `dwell_load` of 10 while D=5 mid-code → current code still lasts 5 cycles, the next lasts 10; `dwell_val`=0 → 1-cycle codes.
- `stop` and `start` in the same cycle during RUN → IDLE, `sel`=0, no `wrap`/`done`. Async reset mid-run at `sel`=37 → all outputs 0 immediately.
- With LIGHT_SEQ_REVERSE_EN, `dir`=1, looping → `sel` 59,58,…,0,59 with a `wrap` pulse at the 0→59 transition.
